instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameters (name, default, meaning): WIDTH, 32, instruction/address width; DEPTH, 4, prefetch FIFO entries (power of 2, >= 2).
REQ-002 SHALL have ports (name, direction, width, meaning):
  clk  input  1  single clock, all logic on rising edge.
  rst  input  1  synchronous, active-high reset.
  instr_addr  input  WIDTH  fetch address driven by the core.
  instr_in  output  WIDTH  instruction word to the core.
  instr_valid  output  1  instr_in corresponds to current instr_addr.
  mem_req  output  1  instruction-memory read request.
  mem_addr  output  WIDTH  read address, word aligned.
  mem_ack  input  1  memory returns mem_rdata for oldest request.
  mem_rdata  input  WIDTH  instruction word from memory.

Function
REQ-003 SHALL hold up to DEPTH entries {addr, word}, each in a FIFO ordered by address, with a head pointer and a tail pointer that both wrap modulo DEPTH; occupancy counter 0..DEPTH.
REQ-004 SHALL keep fetch_pc, the next prefetch address, which advances by 4 on every accepted request and wraps at 2^WIDTH.
REQ-005 SHALL have FSM states IDLE, FETCH, WAIT, DRAIN.
REQ-006 IDLE: entered on reset; next cycle loads fetch_pc=instr_addr, goes to FETCH.
REQ-007 FETCH: mem_req=1, mem_addr=fetch_pc when occupancy < DEPTH; request counts as issued on that edge; goes to WAIT.
REQ-008 WAIT: mem_req=0; on mem_ack, push {mem_addr_reg, mem_rdata} and return to FETCH; one request outstanding max.
REQ-009 Hit: instr_valid=1 and instr_in=head.word combinationally when occupancy>0 and head.addr==instr_addr; otherwise instr_valid=0 and instr_in=0.
REQ-010 Sequential advance: at edge, if occupancy>0 and instr_addr==head.addr+4, pop head (one pop per cycle max).
REQ-011 Redirect: at edge, if instr_addr is neither head.addr nor head.addr+4 (or, when empty, not equal to the outstanding/next fetch address), flush FIFO (occupancy=0) and set fetch_pc=instr_addr.
REQ-012 Redirect while a request is outstanding SHALL go to DRAIN; DRAIN discards the next mem_ack data then goes to FETCH.
REQ-013 Simultaneous push and pop SHALL leave occupancy unchanged; full FIFO SHALL suppress mem_req (FETCH holds).
REQ-014 Redirect in the same cycle as mem_ack SHALL discard that data (no push).
REQ-015 Misaligned instr_addr (bits[1:0]!=0) SHALL be treated as a redirect to instr_addr with bits[1:0] forced to 0.

Reset
REQ-016 On rst: state=IDLE, occupancy=0, pointers=0, fetch_pc=0, mem_req=0, mem_addr=0, instr_valid=0, instr_in=0.
REQ-017 Reset mid-transaction SHALL abandon the outstanding request; a mem_ack in the first cycle after reset SHALL be ignored.

Configuration
REQ-018 Macro FETCH_BUF_BYPASS_EN: when defined, in WAIT with FIFO empty and mem_ack with fetched addr==instr_addr, instr_in=mem_rdata and instr_valid=1 in that same cycle (entry still pushed); when undefined, data is visible only the cycle after push (hit latency = memory latency + 1).

Structure
REQ-019 Shared package SHALL hold the FSM state enum, the entry struct {addr, word}, and the constant INSTR_BYTES=4.
REQ-020 SHALL instantiate one sub-module, fetch_fifo (parameterised sync FIFO: push, pop, flush, full, empty, head data); FSM and compare logic in instr_fetch_buffer.

Verification
REQ-021 Reset then instr_addr=0x0, 1-cycle mem_ack latency, rdata=0x00232BB7 -> mem_addr=0x0, then 0x4; instr_valid=1 with instr_in=0x00232BB7.
REQ-022 Sequential run 0x0..0x1C with memory always acking -> FIFO fills to 4, mem_req drops at full, one pop per address step, no bubbles after warm-up.
REQ-023 Branch: head=0x8, instr_addr jumps to 0x40 -> occupancy=0 next cycle, mem_addr=0x40, instr_valid=0 until 0x40 word returns.
REQ-024 Redirect while a request is outstanding -> stale ack data (e.g. 0x00418463) discarded, no false hit, next mem_addr=new target.
REQ-025 rst asserted in WAIT -> all outputs 0 next cycle, late mem_ack ignored, fetch restarts from instr_addr.
REQ-026 FETCH_BUF_BYPASS_EN defined vs undefined: same stimulus as REQ-021 -> instr_valid rises in ack cycle vs one cycle later.

Source files
------------

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared types for the instruction prefetch buffer: FSM states, FIFO entry layout, fetch stride.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_buffer_pkg;

  // Bytes per instruction word; the prefetch address steps by this amount.
  localparam int INSTR_BYTES = 4;

  // Address/word width of the entry_t view below (matches the default WIDTH).
  localparam int ENTRY_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // One prefetched instruction; the FIFO stores entries packed as {addr, word}.
  typedef struct packed {
    logic [ENTRY_W-1:0] addr;
    logic [ENTRY_W-1:0] word;
  } entry_t;

endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// Synchronous FIFO holding prefetched {addr, word} entries, head visible combinationally.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush empties in one cycle.
module fetch_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] push_dat,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; flush wins over push/pop.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch buffer: sequential prefetch into a FIFO, combinational hit on the core address.
// Latency: hit the cycle after the memory ack (same cycle when FETCH_BUF_BYPASS_EN is defined).
// Backpressure: one outstanding read; mem_req held low while the FIFO is full.
import instr_fetch_buffer_pkg::*;

module instr_fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_addr,
  output logic [WIDTH-1:0] instr_in,
  output logic             instr_valid,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic               fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] push_dat, head_dat;
  logic [WIDTH-1:0]   head_addr, head_word, head_next, addr_al, expect_addr;
  logic               misaligned, redirect, seq_step;

  assign head_addr  = head_dat[2*WIDTH-1:WIDTH];
  assign head_word  = head_dat[WIDTH-1:0];
  assign push_dat   = {mem_addr_q, mem_rdata};
  assign fifo_push  = (state_q == S_WAIT) && mem_ack && !redirect;
  assign fifo_pop   = seq_step;
  assign fifo_flush = redirect;

  fetch_fifo #(
    .DW   (2*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .push_dat(push_dat),
    .head_dat(head_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Classify the core address against the head (or, when empty, the next word due from memory).
  always_comb begin
    addr_al     = {instr_addr[WIDTH-1:2], 2'b00};
    misaligned  = (instr_addr[1:0] != 2'b00);
    head_next   = head_addr + WIDTH'(INSTR_BYTES);
    expect_addr = (state_q == S_WAIT) ? mem_addr_q : fetch_pc_q;
    redirect    = 1'b0;
    seq_step    = 1'b0;
    if (state_q != S_IDLE) begin
      if (misaligned) begin
        redirect = 1'b1;
      end else if (!fifo_empty) begin
        seq_step = (instr_addr == head_next);
        redirect = (instr_addr != head_addr) && !seq_step;
      end else begin
        redirect = (instr_addr != expect_addr);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a redirect with a read in flight must drain its ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_req) state_d = redirect ? S_DRAIN : S_WAIT;
      S_WAIT:  begin
        if (redirect)     state_d = mem_ack ? S_FETCH : S_DRAIN;
        else if (mem_ack) state_d = S_FETCH;
      end
      S_DRAIN: if (mem_ack) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: memory request and the hit path to the core.
  always_comb begin
    mem_req     = (state_q == S_FETCH) && !fifo_full;
    mem_addr    = mem_req ? fetch_pc_q : mem_addr_q;
    instr_valid = 1'b0;
    instr_in    = '0;
    if (!fifo_empty && (head_addr == instr_addr)) begin
      instr_valid = 1'b1;
      instr_in    = head_word;
    end
`ifdef FETCH_BUF_BYPASS_EN
    else if ((state_q == S_WAIT) && fifo_empty && mem_ack && (mem_addr_q == instr_addr)) begin
      instr_valid = 1'b1;
      instr_in    = mem_rdata;
    end
`endif
  end

  // Prefetch address bookkeeping; a redirect overrides the normal advance.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    if (state_q == S_IDLE) fetch_pc_d = addr_al;
    if (mem_req) begin
      mem_addr_d = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);
    end
    if (redirect) fetch_pc_d = addr_al;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= '0;
      mem_addr_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with an optional 1-cycle auto-ack memory.
// Latency: checks sampled 2 time units after the rising edge.
// Backpressure: manual ack control for redirect/drain/reset scenarios.
module tb_instr_fetch_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        mem_auto;
  logic        auto_ack, man_ack;
  logic [31:0] auto_rdata, man_rdata;
  logic        pend_v;
  logic [31:0] pend_a;

  int n_cmp;
  int n_fail;

  assign mem_ack   = mem_auto ? auto_ack : man_ack;
  assign mem_rdata = mem_auto ? auto_rdata : man_rdata;

  instr_fetch_buffer #(.WIDTH(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .instr_valid(instr_valid),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents: a fixed opcode at 0, otherwise an address-tagged word.
  function automatic logic [31:0] w(input logic [31:0] a);
    return (a == 32'h0) ? 32'h00232BB7 : (32'h13000000 | a);
  endfunction

  // Auto memory: request seen before an edge is acked during the following cycle.
  initial begin
    auto_ack = 1'b0; auto_rdata = '0; pend_v = 1'b0; pend_a = '0;
    forever begin
      @(negedge clk);
      if (rst || !mem_auto) pend_v = 1'b0;
      else if (mem_req) begin pend_v = 1'b1; pend_a = mem_addr; end
      @(posedge clk); #1;
      auto_ack = 1'b0; auto_rdata = '0;
      if (pend_v) begin auto_ack = 1'b1; auto_rdata = w(pend_a); pend_v = 1'b0; end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input logic [31:0] a, input logic auto_mode);
    mem_auto = auto_mode; man_ack = 1'b0; man_rdata = '0; instr_addr = a; rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin cyc(); n++; end while (!instr_valid && n < 12);
  endtask

  task automatic test_reset();
    do_reset(32'h0, 1'b1);
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr_in !== 32'h0) begin n_fail++; $display("FAIL rst_instr_in: got %h want 0", instr_in); end
  endtask

  task automatic test_first_fetch();
    logic        ev;
    logic [31:0] ed;
    cyc();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1/0", mem_req, mem_addr); end
    cyc();
`ifdef FETCH_BUF_BYPASS_EN
    ev = 1'b1; ed = 32'h00232BB7;
`else
    ev = 1'b0; ed = 32'h0;
`endif
    n_cmp++; if (instr_valid !== ev || instr_in !== ed) begin n_fail++; $display("FAIL ack_cycle_hit: got v=%b d=%h want v=%b d=%h", instr_valid, instr_in, ev, ed); end
    cyc();
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== 32'h00232BB7) begin n_fail++; $display("FAIL first_hit: got v=%b d=%h want 1/00232bb7", instr_valid, instr_in); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin n_fail++; $display("FAIL second_req: got req=%b addr=%h want 1/4", mem_req, mem_addr); end
  endtask

  task automatic test_fill_and_run();
    int          n;
    logic [31:0] a;
    repeat (10) cyc();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'hC) begin n_fail++; $display("FAIL full_hold: got req=%b addr=%h want 0/c", mem_req, mem_addr); end
      cyc();
    end
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== w(32'h0)) begin n_fail++; $display("FAIL full_head: got v=%b d=%h want 1/%h", instr_valid, instr_in, w(32'h0)); end
    for (int k = 1; k <= 7; k++) begin
      a = 32'(k * 4);
      instr_addr = a;
      wait_valid(n);
      n_cmp++; if (instr_valid !== 1'b1 || instr_in !== w(a)) begin n_fail++; $display("FAIL seq_hit @%h: got v=%b d=%h want 1/%h", a, instr_valid, instr_in, w(a)); end
      if (k <= 3) begin
        n_cmp++; if (n !== 1) begin n_fail++; $display("FAIL seq_no_bubble @%h: got %0d cycles want 1", a, n); end
      end
    end
  endtask

  task automatic test_branch();
    int          n;
    logic        seen, got, bad;
    logic [31:0] first;
    do_reset(32'h0, 1'b1);
    repeat (12) cyc();
    instr_addr = 32'h4; wait_valid(n);
    instr_addr = 32'h8; wait_valid(n);
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== w(32'h8)) begin n_fail++; $display("FAIL br_head8: got v=%b d=%h want 1/%h", instr_valid, instr_in, w(32'h8)); end
    instr_addr = 32'h40; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_miss: got v=%b want 0", instr_valid); end
    seen = 1'b0; got = 1'b0; bad = 1'b0; first = '1;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (mem_req && !seen) begin seen = 1'b1; first = mem_addr; end
      if (instr_valid) begin got = 1'b1; if (instr_in !== w(32'h40)) bad = 1'b1; end
    end
    n_cmp++; if (first !== 32'h40) begin n_fail++; $display("FAIL br_target_req: got %h want 40", first); end
    n_cmp++; if (got !== 1'b1 || bad !== 1'b0) begin n_fail++; $display("FAIL br_target_hit: got hit=%b data=%h want 1/%h", got, instr_in, w(32'h40)); end
  endtask

  task automatic test_drain();
    logic        ev;
    logic [31:0] ed;
    do_reset(32'h100, 1'b0);
    cyc();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin n_fail++; $display("FAIL dr_req100: got req=%b addr=%h want 1/100", mem_req, mem_addr); end
    cyc();
    instr_addr = 32'h200;
    cyc();
    man_ack = 1'b1; man_rdata = 32'h00418463; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL dr_stale: got v=%b req=%b want 0/0", instr_valid, mem_req); end
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL dr_newreq: got req=%b addr=%h v=%b want 1/200/0", mem_req, mem_addr, instr_valid); end
    cyc();
    man_ack = 1'b1; man_rdata = 32'h12345678; #1;
`ifdef FETCH_BUF_BYPASS_EN
    ev = 1'b1; ed = 32'h12345678;
`else
    ev = 1'b0; ed = 32'h0;
`endif
    n_cmp++; if (instr_valid !== ev || instr_in !== ed) begin n_fail++; $display("FAIL dr_ack_cycle: got v=%b d=%h want v=%b d=%h", instr_valid, instr_in, ev, ed); end
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== 32'h12345678) begin n_fail++; $display("FAIL dr_hit: got v=%b d=%h want 1/12345678", instr_valid, instr_in); end
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h204) begin n_fail++; $display("FAIL dr_next: got req=%b addr=%h want 1/204", mem_req, mem_addr); end
    cyc();
    instr_addr = 32'h300; man_ack = 1'b1; man_rdata = 32'hDEAD0001; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL ra_miss: got v=%b want 0", instr_valid); end
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL ra_discard: got req=%b addr=%h v=%b want 1/300/0", mem_req, mem_addr, instr_valid); end
    instr_addr = 32'h302;
    cyc();
    man_ack = 1'b1; man_rdata = 32'hDEAD0002; #1;
    n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL mis_drain: got v=%b req=%b want 0/0", instr_valid, mem_req); end
    cyc();
    man_ack = 1'b0; instr_addr = 32'h300; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL mis_align_req: got req=%b addr=%h want 1/300", mem_req, mem_addr); end
    cyc();
    man_ack = 1'b1; man_rdata = 32'h33330000;
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== 32'h33330000) begin n_fail++; $display("FAIL mis_hit: got v=%b d=%h want 1/33330000", instr_valid, instr_in); end
  endtask

  task automatic test_reset_in_wait();
    logic        ev;
    logic [31:0] ed;
    do_reset(32'h500, 1'b0);
    cyc();
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin n_fail++; $display("FAIL rw_req: got req=%b addr=%h want 1/500", mem_req, mem_addr); end
    cyc();
    rst = 1'b1;
    cyc();
    n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || instr_in !== 32'h0) begin n_fail++; $display("FAIL rw_outputs: got req=%b addr=%h v=%b d=%h want all 0", mem_req, mem_addr, instr_valid, instr_in); end
    rst = 1'b0; man_ack = 1'b1; man_rdata = 32'h0BAD0BAD;
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h500 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_restart: got req=%b addr=%h v=%b want 1/500/0", mem_req, mem_addr, instr_valid); end
    cyc();
    man_ack = 1'b1; man_rdata = 32'h55550000; #1;
`ifdef FETCH_BUF_BYPASS_EN
    ev = 1'b1; ed = 32'h55550000;
`else
    ev = 1'b0; ed = 32'h0;
`endif
    n_cmp++; if (instr_valid !== ev || instr_in !== ed) begin n_fail++; $display("FAIL rw_ack_cycle: got v=%b d=%h want v=%b d=%h", instr_valid, instr_in, ev, ed); end
    cyc();
    man_ack = 1'b0; #1;
    n_cmp++; if (instr_valid !== 1'b1 || instr_in !== 32'h55550000) begin n_fail++; $display("FAIL rw_hit: got v=%b d=%h want 1/55550000", instr_valid, instr_in); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; instr_addr = '0; mem_auto = 1'b1; man_ack = 1'b0; man_rdata = '0;
    test_reset();
    test_first_fetch();
    test_fill_and_run();
    test_branch();
    test_drain();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
